core_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32 core. It sequences instruction fetch, decode, ALU and branch-compare evaluation, data memory access and register write-back by driving the select/enable inputs of the `alu`, `cond`, `ram` and register-file datapath. It sits between the instruction register and the datapath and is the only block that writes the PC.

---
 rtl/core_pkg.sv | 76 +++++++
 rtl/core_ctrl_if.sv | 35 +++
 rtl/core_ctrl_decode.sv | 74 +++++++
 rtl/core_ctrl.sv | 138 +++++++++++++
 tb/tb_core_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core definitions: controller states, opcodes and datapath select encodings.
// The TRAP state exists only when CORE_CTRL_ILLEGAL_TRAP_EN is defined.
package core_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned ALU_CON_W  = 3;
   localparam int unsigned COND_CON_W = 2;
   localparam int unsigned WD_SEL_W   = 2;
   localparam int unsigned PC_SRC_W   = 2;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ALU_CON_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CON_W-1:0] ALU_AND = 3'b001;
   localparam logic [ALU_CON_W-1:0] ALU_OR  = 3'b010;
   localparam logic [ALU_CON_W-1:0] ALU_XOR = 3'b011;
   localparam logic [ALU_CON_W-1:0] ALU_SLT = 3'b100;

   localparam logic [COND_CON_W-1:0] COND_BEQ = 2'b00;
   localparam logic [COND_CON_W-1:0] COND_BNE = 2'b01;
   localparam logic [COND_CON_W-1:0] COND_BLT = 2'b10;
   localparam logic [COND_CON_W-1:0] COND_BGE = 2'b11;

   localparam logic [WD_SEL_W-1:0] WD_ALU = 2'b00;
   localparam logic [WD_SEL_W-1:0] WD_MEM = 2'b01;
   localparam logic [WD_SEL_W-1:0] WD_PC4 = 2'b10;

   localparam logic [PC_SRC_W-1:0] PC_PLUS4  = 2'b00;
   localparam logic [PC_SRC_W-1:0] PC_BRANCH = 2'b01;
   localparam logic [PC_SRC_W-1:0] PC_JAL    = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_EXWAIT,
      ST_MEM,
      ST_WB
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
      , ST_TRAP
`endif
   } state_t;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_ILL
   } instr_class_t;

   // Per-cycle control word driven onto the datapath
   typedef struct packed {
      logic                  mem_req;
      logic                  mem_we;
      logic                  mem_addr_sel;
      logic                  ir_we;
      logic [ALU_CON_W-1:0]  alu_con;
      logic                  alu_mod;
      logic                  alu_b_sel;
      logic [COND_CON_W-1:0] cond_con;
      logic                  rf_we;
      logic [WD_SEL_W-1:0]   rf_wd_sel;
      logic                  pc_we;
      logic [PC_SRC_W-1:0]   pc_src;
      logic                  retire;
   } ctrl_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface core_ctrl_if;
   import core_pkg::*;

   logic [XLEN-1:0]       instr;
   logic                  mem_ready;
   logic                  cond_taken;
   logic                  mem_req;
   logic                  mem_we;
   logic                  mem_addr_sel;
   logic                  ir_we;
   logic [ALU_CON_W-1:0]  alu_con;
   logic                  alu_mod;
   logic                  alu_b_sel;
   logic [COND_CON_W-1:0] cond_con;
   logic                  rf_we;
   logic [WD_SEL_W-1:0]   rf_wd_sel;
   logic                  pc_we;
   logic [PC_SRC_W-1:0]   pc_src;
   logic                  retire;
   logic                  trap;

   modport master (
      input  instr, mem_ready, cond_taken,
      output mem_req, mem_we, mem_addr_sel, ir_we, alu_con, alu_mod, alu_b_sel,
             cond_con, rf_we, rf_wd_sel, pc_we, pc_src, retire, trap
   );

   modport slave (
      output instr, mem_ready, cond_taken,
      input  mem_req, mem_we, mem_addr_sel, ir_we, alu_con, alu_mod, alu_b_sel,
             cond_con, rf_we, rf_wd_sel, pc_we, pc_src, retire, trap
   );

endinterface

// File: rtl/core_ctrl_decode.sv
// Combinational instruction classifier: class, ALU/cond op selects and illegal flag.
module core_ctrl_decode
   import core_pkg::*;
(
   input  logic [XLEN-1:0]       instr,
   output instr_class_t          cls,
   output logic [ALU_CON_W-1:0]  alu_con,
   output logic                  alu_mod,
   output logic [COND_CON_W-1:0] cond_con,
   output logic                  illegal
);

   logic [2:0]           funct3;
   logic [ALU_CON_W-1:0] alu_map;
   logic                 alu_ok;
   logic                 br_ok;
   logic [COND_CON_W-1:0] br_map;
   logic                 unused_bits;

   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Supported ALU and branch funct3 codes; everything else is illegal
   always_comb begin
      alu_map = ALU_ADD;
      alu_ok  = 1'b1;
      br_map  = COND_BEQ;
      br_ok   = 1'b1;
      case (funct3)
         3'b000:  alu_map = ALU_ADD;
         3'b100:  alu_map = ALU_XOR;
         3'b110:  alu_map = ALU_OR;
         3'b111:  alu_map = ALU_AND;
         3'b010:  alu_map = ALU_SLT;
         default: alu_ok  = 1'b0;
      endcase
      case (funct3)
         3'b000:  br_map = COND_BEQ;
         3'b001:  br_map = COND_BNE;
         3'b100:  br_map = COND_BLT;
         3'b101:  br_map = COND_BGE;
         default: br_ok  = 1'b0;
      endcase
   end

   always_comb begin
      cls      = CLS_ILL;
      alu_con  = ALU_ADD;
      alu_mod  = 1'b0;
      cond_con = COND_BEQ;
      case (instr[6:0])
         OP_R: if (alu_ok) begin
            cls     = CLS_R;
            alu_con = alu_map;
            alu_mod = instr[30];
         end
         OP_I: if (alu_ok) begin
            cls     = CLS_I;
            alu_con = alu_map;
         end
         OP_LOAD:  cls = CLS_LOAD;
         OP_STORE: cls = CLS_STORE;
         OP_BRANCH: if (br_ok) begin
            cls      = CLS_BRANCH;
            cond_con = br_map;
         end
         OP_JAL:   cls = CLS_JAL;
         default:  cls = CLS_ILL;
      endcase
   end

   assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32 control FSM: fetch, decode, execute, memory and write-back sequencing.
// CORE_CTRL_ILLEGAL_TRAP_EN: illegal instructions lock up in TRAP instead of retiring as NOPs.
module core_ctrl
   import core_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   core_ctrl_if.master      bus
);

   state_t                state;
   state_t                next_state;
   ctrl_t                 c;
   instr_class_t          cls;
   logic [ALU_CON_W-1:0]  dec_alu_con;
   logic                  dec_alu_mod;
   logic [COND_CON_W-1:0] dec_cond_con;
   logic                  illegal;

   core_ctrl_decode u_decode (
      .instr    (bus.instr),
      .cls      (cls),
      .alu_con  (dec_alu_con),
      .alu_mod  (dec_alu_mod),
      .cond_con (dec_cond_con),
      .illegal  (illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_FETCH;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      c          = '0;
      case (state)
         ST_FETCH: begin
            c.mem_req = 1'b1;
            if (bus.mem_ready) begin
               c.ir_we    = 1'b1;
               next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
            next_state = illegal ? ST_TRAP : ST_EXEC;
`else
            next_state = illegal ? ST_WB : ST_EXEC;
`endif
         end
         // EXWAIT repeats EXEC's selects to cover the registered alu/cond latency
         ST_EXEC, ST_EXWAIT: begin
            c.alu_con   = dec_alu_con;
            c.alu_mod   = dec_alu_mod;
            c.alu_b_sel = (cls inside {CLS_I, CLS_LOAD, CLS_STORE});
            c.cond_con  = dec_cond_con;
            if (state == ST_EXEC) begin
               next_state = ST_EXWAIT;
            end else begin
               case (cls)
                  CLS_BRANCH: begin
                     c.pc_we    = 1'b1;
                     c.pc_src   = bus.cond_taken ? PC_BRANCH : PC_PLUS4;
                     c.retire   = 1'b1;
                     next_state = ST_FETCH;
                  end
                  CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                  default:             next_state = ST_WB;
               endcase
            end
         end
         ST_MEM: begin
            c.mem_req      = 1'b1;
            c.mem_addr_sel = 1'b1;
            c.mem_we       = (cls == CLS_STORE);
            if (bus.mem_ready) begin
               if (cls == CLS_STORE) begin
                  c.pc_we    = 1'b1;
                  c.pc_src   = PC_PLUS4;
                  c.retire   = 1'b1;
                  next_state = ST_FETCH;
               end else begin
                  next_state = ST_WB;
               end
            end
         end
         ST_WB: begin
            c.pc_we    = 1'b1;
            c.retire   = 1'b1;
            next_state = ST_FETCH;
            case (cls)
               CLS_R, CLS_I: begin
                  c.rf_we     = 1'b1;
                  c.rf_wd_sel = WD_ALU;
               end
               CLS_LOAD: begin
                  c.rf_we     = 1'b1;
                  c.rf_wd_sel = WD_MEM;
               end
               CLS_JAL: begin
                  c.rf_we     = 1'b1;
                  c.rf_wd_sel = WD_PC4;
                  c.pc_src    = PC_JAL;
               end
               default: c.rf_we = 1'b0;
            endcase
         end
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
         ST_TRAP: next_state = ST_TRAP;
`endif
         default: next_state = ST_FETCH;
      endcase
      // Outputs are forced low for the whole reset window, not just after the edge
      if (rst) c = '0;
   end

   assign bus.mem_req      = c.mem_req;
   assign bus.mem_we       = c.mem_we;
   assign bus.mem_addr_sel = c.mem_addr_sel;
   assign bus.ir_we        = c.ir_we;
   assign bus.alu_con      = c.alu_con;
   assign bus.alu_mod      = c.alu_mod;
   assign bus.alu_b_sel    = c.alu_b_sel;
   assign bus.cond_con     = c.cond_con;
   assign bus.rf_we        = c.rf_we;
   assign bus.rf_wd_sel    = c.rf_wd_sel;
   assign bus.pc_we        = c.pc_we;
   assign bus.pc_src       = c.pc_src;
   assign bus.retire       = c.retire;

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
   assign bus.trap = (state == ST_TRAP);
`else
   assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: directed instructions, expected retire records checked by a monitor.
module tb_core_ctrl;
   import core_pkg::*;

   typedef struct {
      string      name;
      int         cycles;
      logic [1:0] pc_src;
      logic       rf_we;
      logic [1:0] wd;
      logic [2:0] alu;
      logic       mod;
      logic [1:0] cnd;
      logic       bsel;
      int         hs;
      logic       last_sel;
      logic       last_we;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    checks = 0;
   int    errors = 0;
   exp_t  exp_q[$];
   int    fetch_wait = 0;
   int    mem_wait = 0;
   logic [18:0] outs;

   always #5 clk = ~clk;

   core_ctrl_if bus();

   core_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.alu_con, bus.alu_mod,
                  bus.alu_b_sel, bus.cond_con, bus.rf_we, bus.rf_wd_sel, bus.pc_we, bus.pc_src,
                  bus.retire, bus.trap};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input string n, input int cyc, input logic [1:0] ps, input logic rw,
                               input logic [1:0] wd, input logic [2:0] alu, input logic md,
                               input logic [1:0] cnd, input logic bs, input int hs,
                               input logic ls, input logic lw);
      exp_t e;
      e.name = n; e.cycles = cyc; e.pc_src = ps; e.rf_we = rw; e.wd = wd; e.alu = alu;
      e.mod = md; e.cnd = cnd; e.bsel = bs; e.hs = hs; e.last_sel = ls; e.last_we = lw;
      return e;
   endfunction

   // Memory responder: ready after fetch_wait / mem_wait extra cycles of a request
   initial begin
      int wcnt;
      wcnt = 0;
      bus.mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !bus.mem_req) begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
         end else begin
            bus.mem_ready = (wcnt == (bus.mem_addr_sel ? mem_wait : fetch_wait));
            if (bus.mem_ready) wcnt = 0;
            else               wcnt++;
         end
      end
   end

   // Monitor: accumulates per-instruction activity and scores it at each retire
   initial begin
      int   cnt, hs;
      logic rf_or, mod_or, bsel_or, last_sel, last_we;
      logic [2:0] alu_or;
      logic [1:0] cnd_or;
      logic prev_req, prev_rdy, prev_we, prev_sel;
      exp_t e;
      cnt = 0; hs = 0; rf_or = 0; mod_or = 0; bsel_or = 0; alu_or = 0; cnd_or = 0;
      last_sel = 0; last_we = 0; prev_req = 0; prev_rdy = 0; prev_we = 0; prev_sel = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt = 0; hs = 0; rf_or = 0; mod_or = 0; bsel_or = 0; alu_or = 0; cnd_or = 0;
            prev_req = 0;
         end else begin
            cnt++;
            rf_or   |= bus.rf_we;
            mod_or  |= bus.alu_mod;
            bsel_or |= bus.alu_b_sel;
            alu_or  |= bus.alu_con;
            cnd_or  |= bus.cond_con;
            if (bus.mem_req && bus.mem_ready) begin
               hs++;
               last_sel = bus.mem_addr_sel;
               last_we  = bus.mem_we;
            end
            if (prev_req && !prev_rdy)
               chk("mem_hold", 32'({bus.mem_req, bus.mem_we, bus.mem_addr_sel}),
                   32'({1'b1, prev_we, prev_sel}));
            prev_req = bus.mem_req; prev_rdy = bus.mem_ready;
            prev_we  = bus.mem_we;  prev_sel = bus.mem_addr_sel;
            if (bus.pc_we || bus.retire) chk("pc_we_vs_retire", 32'(bus.pc_we), 32'(bus.retire));
            if (bus.retire) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_retire actual=1 required=0 at cycle %0d", cnt);
               end else begin
                  e = exp_q.pop_front();
                  chk({e.name, "_cycles"},   32'(cnt),        32'(e.cycles));
                  chk({e.name, "_pc_src"},   32'(bus.pc_src), 32'(e.pc_src));
                  chk({e.name, "_rf_we"},    32'(rf_or),      32'(e.rf_we));
                  chk({e.name, "_wd_sel"},   32'(bus.rf_wd_sel), 32'(e.wd));
                  chk({e.name, "_alu_con"},  32'(alu_or),     32'(e.alu));
                  chk({e.name, "_alu_mod"},  32'(mod_or),     32'(e.mod));
                  chk({e.name, "_cond_con"}, 32'(cnd_or),     32'(e.cnd));
                  chk({e.name, "_b_sel"},    32'(bsel_or),    32'(e.bsel));
                  chk({e.name, "_mem_hs"},   32'({hs[7:0], last_sel, last_we}),
                      32'({8'(e.hs), e.last_sel, e.last_we}));
               end
               cnt = 0; hs = 0; rf_or = 0; mod_or = 0; bsel_or = 0; alu_or = 0; cnd_or = 0;
            end
         end
      end
   end

   task automatic start(input logic [31:0] ins, input int fw, input int mw, input logic ct);
      @(posedge clk);
      #1;
      bus.instr = ins; fetch_wait = fw; mem_wait = mw; bus.cond_taken = ct;
      rst = 1'b0;
   endtask

   task automatic wait_retire(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.retire && n < 40);
      if (!bus.retire) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_retire required=retire within 40 cycles", name);
      end
   endtask

   task automatic issue(input logic [31:0] ins, input int fw, input int mw, input logic ct,
                        input exp_t e);
      exp_q.push_back(e);
      start(ins, fw, mw, ct);
      wait_retire(e.name);
   endtask

   initial begin
      logic found;
      bus.instr = 32'h0; bus.cond_taken = 1'b0;
      @(negedge clk);
      chk("reset_outs", 32'(outs), 32'd0);

      issue(32'h002081B3, 0, 0, 1'b0, mk("add",   5, 2'b00, 1, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h402081B3, 0, 0, 1'b0, mk("sub",   5, 2'b00, 1, 2'b00, 3'b000, 1, 2'b00, 0, 1, 0, 0));
      issue(32'h0000A183, 2, 1, 1'b0, mk("lw",    9, 2'b00, 1, 2'b01, 3'b000, 0, 2'b00, 1, 2, 1, 0));
      issue(32'h00208463, 0, 0, 1'b1, mk("beq_t", 4, 2'b01, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h00208463, 0, 0, 1'b0, mk("beq_n", 4, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h0FF0C093, 0, 0, 1'b0, mk("xori",  5, 2'b00, 1, 2'b00, 3'b011, 0, 2'b00, 1, 1, 0, 0));
      issue(32'h40008093, 0, 0, 1'b0, mk("addi",  5, 2'b00, 1, 2'b00, 3'b000, 0, 2'b00, 1, 1, 0, 0));
      issue(32'h0050A093, 0, 0, 1'b0, mk("slti",  5, 2'b00, 1, 2'b00, 3'b100, 0, 2'b00, 1, 1, 0, 0));
      issue(32'h0020F1B3, 0, 0, 1'b0, mk("and",   5, 2'b00, 1, 2'b00, 3'b001, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h0020E1B3, 0, 0, 1'b0, mk("or",    5, 2'b00, 1, 2'b00, 3'b010, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h008000EF, 0, 0, 1'b0, mk("jal",   5, 2'b10, 1, 2'b10, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h0020A023, 1, 0, 1'b0, mk("sw",    6, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 1, 2, 1, 1));
      issue(32'h0020D463, 0, 0, 1'b1, mk("bge",   4, 2'b01, 0, 2'b00, 3'b000, 0, 2'b11, 0, 1, 0, 0));
      issue(32'h0020C463, 0, 0, 1'b0, mk("blt",   4, 2'b00, 0, 2'b00, 3'b000, 0, 2'b10, 0, 1, 0, 0));

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
      start(32'h0000007F, 0, 0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k >= 3) chk("trap_hold", 32'({bus.trap, bus.mem_req, bus.retire, bus.pc_we}), 32'h8);
         else        chk("trap_early", 32'(bus.trap), 32'd0);
      end
      #1 rst = 1'b1;
      #1 chk("trap_cleared", 32'(outs), 32'd0);
`else
      issue(32'h0000007F, 0, 0, 1'b0, mk("nop",   3, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      issue(32'h002091B3, 0, 0, 1'b0, mk("sll",   3, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      chk("trap_tied", 32'(bus.trap), 32'd0);
`endif

      // Abort a store mid-MEM with an asynchronous reset
      start(32'h0020A023, 0, 20, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr_sel) found = 1'b1;
      end
      chk("sw_reached_mem", 32'(found), 32'd1);
      #1 rst = 1'b1;
      #1 chk("rst_async_outs", 32'(outs), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_outs", 32'(outs), 32'd0);
      end
      exp_q.push_back(mk("add_post", 5, 2'b00, 1, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0, 0));
      start(32'h002081B3, 0, 0, 1'b0);
      @(negedge clk);
      chk("post_rst_fetch", 32'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 32'b100);
      wait_retire("add_post");

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
